// File: rtl/dff_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// dff_ctrl_pkg
//
// Purpose : shared definitions for the round-robin register writer.
//   - state_t       : sequencer state encoding (IDLE, GRANT, COMMIT)
//   - MAX_REQ       : widest requester vector the helpers support
//   - calc_idx_w()  : index width for a requester count ($clog2, minimum 1)
//   - onehot_to_idx : converts a one-hot vector (up to MAX_REQ bits) to an index
// ---------------------------------------------------------------------------
package dff_ctrl_pkg;

  localparam int MAX_REQ = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT  = 2'd1,
    COMMIT = 2'd2
  } state_t;

  // Index width for n requesters. A single requester still gets a 1-bit
  // index so that owner/pointer ports never collapse to zero width.
  function automatic int calc_idx_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // OR-combines the positions of all set bits. For a true one-hot input this
  // is exactly the index of the set bit; an all-zero input yields 0.
  function automatic int onehot_to_idx(input logic [MAX_REQ-1:0] onehot);
    int idx;
    idx = 0;
    for (int i = 0; i < MAX_REQ; i++) begin
      if (onehot[i]) begin
        idx = idx | i;
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/dff_bank_rr_writer_rr_select.sv
// ---------------------------------------------------------------------------
// rr_select
//
// Purpose : purely combinational round-robin picker. Starting at position
//           ptr and wrapping modulo NUM_REQ, returns the first requester
//           whose req bit is set and whose mask bit is clear.
//
// Ports   :
//   req    in  NUM_REQ  request vector
//   mask   in  NUM_REQ  requesters excluded from this scan
//   ptr    in  IDX_W    scan start position (0..NUM_REQ-1)
//   winner out NUM_REQ  one-hot winner, all zero when nothing eligible
//   idx    out IDX_W    index of winner (0 when nothing eligible)
// ---------------------------------------------------------------------------
module rr_select
  import dff_ctrl_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] mask,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] winner,
  output logic [IDX_W-1:0]   idx
);

  logic [NUM_REQ-1:0] w_elig;
  logic [IDX_W-1:0]   w_pos;
  logic               w_found;

  assign w_elig = req & ~mask;

  // Walk positions ptr, ptr+1, ... with an explicit wrap so the position
  // stays in range even when NUM_REQ is not a power of two.
  always_comb begin
    winner  = '0;
    w_found = 1'b0;
    w_pos   = ptr;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!w_found && w_elig[w_pos]) begin
        w_found        = 1'b1;
        winner[w_pos]  = 1'b1;
      end
      w_pos = (w_pos == IDX_W'(NUM_REQ - 1)) ? '0 : w_pos + IDX_W'(1);
    end
  end

  assign idx = IDX_W'(onehot_to_idx(MAX_REQ'(winner)));

endmodule

// File: rtl/dff_bank_rr_writer.sv
// ---------------------------------------------------------------------------
// dff_bank_rr_writer
//
// Purpose : round-robin write arbiter / sequencer for one shared WIDTH-bit
//           register. One requester is granted at a time; in the following
//           cycle its data slice is loaded, it receives a one-cycle ack and
//           the round-robin pointer moves past it.
//
// Ports   :
//   clk        in  1               rising-edge clock
//   reset      in  1               asynchronous reset, active low
//   req_i      in  NUM_REQ         level requests, held until ack
//   d_i        in  NUM_REQ*WIDTH   packed data, slice k = d_i[k*WIDTH +: WIDTH]
//   gnt_o      out NUM_REQ         one-hot registered grant
//   ack_o      out NUM_REQ         one-hot single-cycle write acknowledge
//   q_o        out WIDTH           shared register contents
//   q_valid_o  out 1               set once any write has committed
//   owner_o    out IDX_W           index of last committed writer
// ---------------------------------------------------------------------------
module dff_bank_rr_writer
  import dff_ctrl_pkg::*;
#(
  parameter int               NUM_REQ   = 4,
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  localparam int              IDX_W     = calc_idx_w(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req_i,
  input  logic [NUM_REQ*WIDTH-1:0] d_i,
  output logic [NUM_REQ-1:0]       gnt_o,
  output logic [NUM_REQ-1:0]       ack_o,
  output logic [WIDTH-1:0]         q_o,
  output logic                     q_valid_o,
  output logic [IDX_W-1:0]         owner_o
);

  state_t             r_state;
  logic [IDX_W-1:0]   r_ptr;
  logic [NUM_REQ-1:0] r_gnt;
  logic [IDX_W-1:0]   r_gnt_idx;
  logic [NUM_REQ-1:0] r_ack;
  logic [WIDTH-1:0]   r_q;
  logic               r_q_valid;
  logic [IDX_W-1:0]   r_owner;

  logic [NUM_REQ-1:0] w_mask;
  logic [NUM_REQ-1:0] w_winner;
  logic [IDX_W-1:0]   w_win_idx;
  logic               w_any;
  logic [IDX_W-1:0]   w_ptr_adv;
  logic [WIDTH-1:0]   w_d [NUM_REQ];

  // Unpack the flat data bus so the granted slice can be picked by index.
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign w_d[gi] = d_i[gi*WIDTH +: WIDTH];
  end

  // While committing, the requester just served may still show req high for
  // this one cycle (it drops after seeing the ack), so it is kept out of the
  // back-to-back scan. In IDLE r_gnt is zero, making the mask a no-op there.
  assign w_mask = (r_state == COMMIT) ? r_gnt : '0;

  rr_select #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_select (
    .req    (req_i),
    .mask   (w_mask),
    .ptr    (r_ptr),
    .winner (w_winner),
    .idx    (w_win_idx)
  );

  assign w_any     = |w_winner;
  assign w_ptr_adv = (r_gnt_idx == IDX_W'(NUM_REQ - 1)) ? '0 : r_gnt_idx + IDX_W'(1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= IDLE;
      r_ptr     <= '0;
      r_gnt     <= '0;
      r_gnt_idx <= '0;
      r_ack     <= '0;
      r_q       <= RESET_VAL;
      r_q_valid <= 1'b0;
      r_owner   <= '0;
    end else begin
      // ack is a single-cycle pulse; only the GRANT branch re-asserts it.
      r_ack <= '0;
      case (r_state)
        IDLE, COMMIT: begin
          if (w_any) begin
            r_gnt     <= w_winner;
            r_gnt_idx <= w_win_idx;
            r_state   <= GRANT;
          end else begin
            r_gnt   <= '0;
            r_state <= IDLE;
          end
        end

        GRANT: begin
          // The pointer moves past the granted requester whether or not it
          // actually wrote, so a withdrawn request does not keep priority.
          r_ptr <= w_ptr_adv;
          if (req_i[r_gnt_idx]) begin
            r_q       <= w_d[r_gnt_idx];
            r_ack     <= r_gnt;
            r_owner   <= r_gnt_idx;
            r_q_valid <= 1'b1;
            r_state   <= COMMIT;
          end else begin
            r_gnt   <= '0;
            r_state <= IDLE;
          end
        end

        default: begin
          r_gnt   <= '0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign gnt_o     = r_gnt;
  assign ack_o     = r_ack;
  assign q_o       = r_q;
  assign q_valid_o = r_q_valid;
  assign owner_o   = r_owner;

endmodule

// File: tb/tb_dff_bank_rr_writer.sv
// ---------------------------------------------------------------------------
// tb_dff_bank_rr_writer
//
// Directed stimulus from the main initial block; every expected write
// (requester index + data) is pushed into a scoreboard queue when the
// request is issued. An independent monitor pops and compares on every
// ack pulse. Timing-specific checks (grant latency, withdrawals, async
// reset, idle behaviour) are made inline by the stimulus process.
// ---------------------------------------------------------------------------
module tb_dff_bank_rr_writer;

  localparam int             N  = 4;
  localparam int             W  = 8;
  localparam logic [W-1:0]   RV = 8'h5E;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic [N-1:0]   req = '0;
  logic [N*W-1:0] d = '0;
  logic [N-1:0]   gnt_o;
  logic [N-1:0]   ack_o;
  logic [W-1:0]   q_o;
  logic           q_valid_o;
  logic [1:0]     owner_o;

  dff_bank_rr_writer #(
    .NUM_REQ   (N),
    .WIDTH     (W),
    .RESET_VAL (RV)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req_i     (req),
    .d_i       (d),
    .gnt_o     (gnt_o),
    .ack_o     (ack_o),
    .q_o       (q_o),
    .q_valid_o (q_valid_o),
    .owner_o   (owner_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    int           idx;
    logic [W-1:0] data;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  int n_cmp = 0;
  int n_bad = 0;

  int           cycle = 0;
  int           last_ack = -1;
  bit           track_gap = 1'b0;
  bit           reraise_en = 1'b0;
  int           served[N];
  bit           pend[N];
  logic [W-1:0] next_data[N];

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp_v, $time);
    end
  endfunction

  task automatic push(input int idx, input logic [W-1:0] v);
    exp_t e;
    e.idx  = idx;
    e.data = v;
    exp_q.push_back(e);
  endtask

  // Scoreboard monitor: one comparison set per ack pulse.
  always @(negedge clk) begin
    if (reset) begin
      check("gnt_multi_hot", 32'($countones(gnt_o) > 1), 0);
      if (ack_o !== '0) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_ack: ack_o=%b with empty scoreboard", ack_o);
        end else begin
          mon_e = exp_q.pop_front();
          check("ack_vec", ack_o, 32'(1) << mon_e.idx);
          check("q_data", q_o, mon_e.data);
          check("owner", owner_o, mon_e.idx);
          check("q_valid", q_valid_o, 1);
          $display("write: req %0d data %02h ack=%b q=%02h owner=%0d", mon_e.idx, mon_e.data, ack_o, q_o, owner_o);
        end
      end
    end
  end

  // One clock of requester behaviour: re-raise pending requests, drop any
  // request that was just acknowledged, and measure the spacing of acks.
  task automatic cyc();
    @(negedge clk);
    cycle++;
    for (int k = 0; k < N; k++) begin
      if (pend[k]) begin
        pend[k]     = 1'b0;
        req[k]      = 1'b1;
        d[k*W +: W] = next_data[k];
      end
    end
    for (int k = 0; k < N; k++) begin
      if (ack_o[k] === 1'b1) begin
        req[k] = 1'b0;
        served[k]++;
        if (reraise_en && served[k] < 2) pend[k] = 1'b1;
      end
    end
    if (ack_o !== '0) begin
      if (track_gap && last_ack >= 0) check("ack_gap", cycle - last_ack, 2);
      last_ack = cycle;
    end
  endtask

  function automatic bit any_pend();
    bit r;
    r = 1'b0;
    for (int k = 0; k < N; k++) r = r | pend[k];
    return r;
  endfunction

  task automatic wait_idle(input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      cyc();
      if (req == '0 && !any_pend() && gnt_o == '0) ok = 1'b1;
    end
    check(name, ok, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    for (int k = 0; k < N; k++) begin
      served[k]    = 0;
      pend[k]      = 1'b0;
      next_data[k] = '0;
    end

    // Reset asserted before any clock edge: outputs must clear asynchronously.
    #1 reset = 1'b0;
    #2;
    check("rst_gnt", gnt_o, 0);
    check("rst_ack", ack_o, 0);
    check("rst_q", q_o, RV);
    check("rst_q_valid", q_valid_o, 0);
    check("rst_owner", owner_o, 0);
    cyc();
    cyc();
    reset = 1'b1;

    // Single request from requester 2.
    req = 4'b0100;
    d[2*W +: W] = 8'hA5;
    push(2, 8'hA5);
    cyc();
    check("single_gnt", gnt_o, 4'b0100);
    check("single_no_early_ack", ack_o, 0);
    cyc();
    check("single_ack_lat", ack_o, 4'b0100);
    check("single_q", q_o, 8'hA5);
    wait_idle("single_idle");
    $display("txn single: done");

    // Pointer is 3 after requester 2 wrote: 3 first, then wrap to 0.
    req = 4'b1001;
    d[3*W +: W] = 8'h3C;
    d[0*W +: W] = 8'hC3;
    push(3, 8'h3C);
    push(0, 8'hC3);
    cyc();
    check("wrap_first_gnt", gnt_o, 4'b1000);
    wait_idle("wrap_idle");
    $display("txn wrap: done");

    // Withdrawn request: requester 1 granted, then drops req during GRANT.
    req = 4'b0010;
    d[1*W +: W] = 8'h5A;
    cyc();
    check("wd_gnt", gnt_o, 4'b0010);
    req = 4'b0000;
    cyc();
    check("wd_gnt_clr", gnt_o, 0);
    check("wd_no_ack", ack_o, 0);
    check("wd_q_kept", q_o, 8'hC3);
    check("wd_owner_kept", owner_o, 0);
    check("wd_valid_kept", q_valid_o, 1);
    cyc();
    check("wd_no_late_ack", ack_o, 0);
    // Pointer should now be 2: with req 0 and 1 both pending, 0 wins first.
    req = 4'b0011;
    d[0*W +: W] = 8'hD0;
    d[1*W +: W] = 8'hD1;
    push(0, 8'hD0);
    push(1, 8'hD1);
    cyc();
    check("wd_ptr_probe_gnt", gnt_o, 4'b0001);
    wait_idle("wd_idle");
    $display("txn withdraw: done");

    // Async reset in the middle of a transfer (state GRANT).
    req = 4'b0100;
    d[2*W +: W] = 8'h77;
    cyc();
    check("ar_gnt", gnt_o, 4'b0100);
    #2;
    reset = 1'b0;
    req   = 4'b0000;
    #1;
    check("ar_gnt_clr", gnt_o, 0);
    check("ar_q", q_o, RV);
    check("ar_q_valid", q_valid_o, 0);
    check("ar_owner", owner_o, 0);
    check("ar_ack", ack_o, 0);
    cyc();
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cyc();
      check("ar_no_ack_after", ack_o, 0);
    end
    check("ar_valid_after", q_valid_o, 0);
    $display("txn async_reset: done");

    // Full contention, two rounds; pointer starts at 0 after reset.
    for (int k = 0; k < N; k++) served[k] = 0;
    next_data[0] = 8'h55;
    next_data[1] = 8'h66;
    next_data[2] = 8'h77;
    next_data[3] = 8'h88;
    reraise_en = 1'b1;
    track_gap  = 1'b1;
    last_ack   = -1;
    d   = {8'h44, 8'h33, 8'h22, 8'h11};
    req = 4'b1111;
    push(0, 8'h11);
    push(1, 8'h22);
    push(2, 8'h33);
    push(3, 8'h44);
    push(0, 8'h55);
    push(1, 8'h66);
    push(2, 8'h77);
    push(3, 8'h88);
    cyc();
    check("cont_first_gnt", gnt_o, 4'b0001);
    wait_idle("cont_idle");
    reraise_en = 1'b0;
    track_gap  = 1'b0;
    for (int k = 0; k < N; k++) check("cont_served", served[k], 2);
    $display("txn contention: done");

    // No requests for 20 cycles.
    for (int i = 0; i < 20; i++) begin
      cyc();
      check("idle_gnt", gnt_o, 0);
      check("idle_ack", ack_o, 0);
      check("idle_q", q_o, 8'h88);
    end
    $display("txn idle: done");

    check("scoreboard_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
